sig_frame_rx: RTL

- Receiver at the monitor end of the single-bit `sig` link. The driver side serialises frames onto `sig`; this block deserialises them.
- It samples one bit per clock, checks parity and stop bits, and presents each frame on a one-entry valid/ready output.
- It keeps saturating frame and error counters for scoreboard cross-checks.
- It sits between the `sig` line and the checker/consumer logic in the constrained-random bench's DUT.

---
 rtl/sig_rx_pkg.sv | 22 ++
 rtl/sig_rx_holdbuf.sv | 57 +++++
 rtl/sig_frame_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sig_rx_pkg.sv
// Shared types and defaults for the sig link receiver.
package sig_rx_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_PARITY_EN = 1;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Frame layout as held in the output slot; the top packs the same order for any DATA_W.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  parity_err;
    logic                  frame_err;
  } rx_frame_t;

endpackage

// File: rtl/sig_rx_holdbuf.sv
// One-entry valid/ready holding register; a load into a full, non-draining slot is dropped.
module sig_rx_holdbuf
  import sig_rx_pkg::*;
#(
  parameter int W = $bits(rx_frame_t)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         overrun_o,
  output logic         drop_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         overrun_q, overrun_d;
  logic         free_s;

  // Slot is free when empty or being drained in this very cycle.
  always_comb begin
    free_s    = !valid_q || ready_i;
    drop_o    = load_i && !free_s;
    overrun_d = drop_o;
    if (load_i && free_s) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      data_d  = data_q;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sig_frame_rx.sv
// Deserialiser for the single-bit sig link: start, LSB-first data, optional even parity, stop.
module sig_frame_rx
  import sig_rx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PARITY_EN = DEF_PARITY_EN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sig,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              p_err_q, p_err_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              done_s, drop_s, bad_s;
  logic [DATA_W+1:0] frame_s, held_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Frame sequencer: one bit per clock; STOP always returns to IDLE so a bad stop is never a start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    p_err_d = p_err_q;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sig) begin
          state_d = DATA;
          idx_d   = '0;
          p_err_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        shift_d[idx_q] = sig;
        if (idx_q == IDX_LAST) begin
          if (PARITY_EN != 0) begin
            state_d = PARITY;
          end else begin
            state_d = STOP;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      PARITY: begin
        p_err_d = (sig != even_par(shift_q));
        state_d = STOP;
      end
      STOP: begin
        done_s  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The stop bit itself is the frame_err flag, taken straight off the line.
  always_comb begin
    frame_s = {shift_q, p_err_q, sig};
    bad_s   = p_err_q || sig || drop_s;
    if (done_s) begin
      frame_cnt_d = sat_inc(frame_cnt_q);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (done_s && bad_s) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Sequencer, shift register and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      p_err_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      p_err_q     <= p_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  sig_rx_holdbuf #(
    .W (DATA_W + 2)
  ) u_holdbuf (
    .clk         (clk),
    .reset       (reset),
    .load_i      (done_s),
    .load_data_i (frame_s),
    .ready_i     (rx_ready),
    .valid_o     (rx_valid),
    .data_o      (held_s),
    .overrun_o   (overrun),
    .drop_o      (drop_s)
  );

  assign rx_data    = held_s[DATA_W+1:2];
  assign parity_err = held_s[1];
  assign frame_err  = held_s[0];
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
